// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port between the UART loader (master) and the Fetch-owned SRAM (slave).
interface imem_uart_loader_if;
  logic [31:0] imem_din;
  logic [31:0] imem_addr;
  logic        imem_web;

  modport master (output imem_din, output imem_addr, output imem_web);
  modport slave  (input  imem_din, input  imem_addr, input  imem_web);
endinterface

// File: rtl/imem_uart_loader.sv
// Receives a count-prefixed program image over 8N1 UART and writes it as little-endian words into imem,
// holding the core in reset until the image is complete.
//   RX state  | meaning                 Loader state | meaning
//   RX_IDLE   | line idle, await fall   L_WAIT_CNT   | first byte is word count
//   RX_START  | verify start mid-bit    L_RECV       | assembling 4 bytes of a word
//   RX_DATA   | shift 8 bits, LSB first L_WRITE      | single-cycle write strobe
//   RX_STOP   | check stop bit          L_DONE       | image loaded, core released
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx,
  imem_uart_loader_if.master imem,
  output logic               o_cpu_rst,
  output logic               o_load_done,
  output logic               o_frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = (ADDR_WIDTH + 1 > 9) ? ADDR_WIDTH + 1 : 9;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_WAIT_CNT, L_RECV, L_WRITE, L_DONE} ld_state_t;

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_bit_idx, w_bit_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_byte_valid, w_byte_valid_nxt;
  logic          r_frame_err, w_frame_err_nxt;
  logic          w_timer_tc;

  ld_state_t     r_l_state, w_l_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [CW-1:0] r_word_idx, w_word_idx_nxt;
  logic [CW-1:0] w_idx_inc, w_cnt_in, w_cnt_clamped;
  logic [1:0]    r_byte_cnt, w_byte_cnt_nxt;
  logic [23:0]   r_word, w_word_nxt;
  logic [31:0]   r_imem_din, w_din_nxt;
  logic [31:0]   r_imem_addr, w_addr_nxt;
  logic          r_imem_web, w_web_nxt;
  logic          r_cpu_rst, w_cpu_rst_nxt;
  logic          r_load_done, w_load_done_nxt;

  assign w_timer_tc    = (r_timer == '0);
  assign w_idx_inc     = r_word_idx + CW'(1);
  assign w_cnt_in      = CW'(r_shift);
  assign w_cnt_clamped = (w_cnt_in > MAX_WORDS) ? MAX_WORDS : w_cnt_in;

  // rx is asynchronous; r_rx_prev only feeds the falling-edge detector
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_state   <= RX_IDLE;
      r_timer      <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_state   <= w_rx_state_nxt;
      r_timer      <= w_timer_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_timer_nxt      = r_timer;
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_byte_valid_nxt = 1'b0;
    w_frame_err_nxt  = r_frame_err;
    case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_timer_nxt    = T_HALF;
        end
      end
      RX_START: begin
        if (!w_timer_tc) begin
          w_timer_nxt = r_timer - TW'(1);
        end else if (!r_rx_sync) begin
          w_rx_state_nxt = RX_DATA;
          w_timer_nxt    = T_FULL;
          w_bit_idx_nxt  = '0;
        end else begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!w_timer_tc) begin
          w_timer_nxt = r_timer - TW'(1);
        end else begin
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          w_timer_nxt   = T_FULL;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!w_timer_tc) begin
          w_timer_nxt = r_timer - TW'(1);
        end else begin
          w_rx_state_nxt = RX_IDLE;
          if (r_rx_sync) w_byte_valid_nxt = 1'b1;
          else           w_frame_err_nxt  = 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_l_state   <= L_WAIT_CNT;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_imem_din  <= '0;
      r_imem_addr <= '0;
      r_imem_web  <= 1'b1;
      r_cpu_rst   <= 1'b1;
      r_load_done <= 1'b0;
    end else begin
      r_l_state   <= w_l_state_nxt;
      r_count     <= w_count_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_word      <= w_word_nxt;
      r_imem_din  <= w_din_nxt;
      r_imem_addr <= w_addr_nxt;
      r_imem_web  <= w_web_nxt;
      r_cpu_rst   <= w_cpu_rst_nxt;
      r_load_done <= w_load_done_nxt;
    end
  end

  // Outputs are registered on entry to a state, so web is low exactly while in L_WRITE
  always_comb begin
    w_l_state_nxt   = r_l_state;
    w_count_nxt     = r_count;
    w_word_idx_nxt  = r_word_idx;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_word_nxt      = r_word;
    w_din_nxt       = r_imem_din;
    w_addr_nxt      = r_imem_addr;
    w_web_nxt       = 1'b1;
    w_cpu_rst_nxt   = r_cpu_rst;
    w_load_done_nxt = r_load_done;
    case (r_l_state)
      L_WAIT_CNT, L_DONE: begin
        if (r_byte_valid) begin
          w_count_nxt    = w_cnt_clamped;
          w_word_idx_nxt = '0;
          w_byte_cnt_nxt = '0;
          if (w_cnt_clamped == '0) begin
            w_l_state_nxt   = L_DONE;
            w_load_done_nxt = 1'b1;
            w_cpu_rst_nxt   = 1'b0;
          end else begin
            w_l_state_nxt   = L_RECV;
            w_load_done_nxt = 1'b0;
            w_cpu_rst_nxt   = 1'b1;
          end
        end
      end
      L_RECV: begin
        if (r_byte_valid) begin
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          case (r_byte_cnt)
            2'd0: w_word_nxt[7:0]   = r_shift;
            2'd1: w_word_nxt[15:8]  = r_shift;
            2'd2: w_word_nxt[23:16] = r_shift;
            2'd3: begin
              w_l_state_nxt = L_WRITE;
              w_web_nxt     = 1'b0;
              w_din_nxt     = {r_shift, r_word};
              w_addr_nxt    = 32'({r_word_idx, 2'b00});
            end
            default: ;
          endcase
        end
      end
      L_WRITE: begin
        w_word_idx_nxt = w_idx_inc;
        w_byte_cnt_nxt = '0;
        if (w_idx_inc == r_count) begin
          w_l_state_nxt   = L_DONE;
          w_load_done_nxt = 1'b1;
          w_cpu_rst_nxt   = 1'b0;
        end else begin
          w_l_state_nxt = L_RECV;
        end
      end
      default: w_l_state_nxt = L_WAIT_CNT;
    endcase
  end

  assign imem.imem_din  = r_imem_din;
  assign imem.imem_addr = r_imem_addr;
  assign imem.imem_web  = r_imem_web;
  assign o_cpu_rst      = r_cpu_rst;
  assign o_load_done    = r_load_done;
  assign o_frame_err    = r_frame_err;

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer side of the instruction-memory load interface; the Fetch stage is the reader and owns the SRAM.
- Receives a program image over a UART serial line (8N1) and assembles little-endian 32-bit words.
- Drives the imem write port (imem_din, imem_addr, imem_web) with one write strobe per word.
- Holds the core in reset via cpu_rst until the image is fully written.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_WIDTH, 5, imem word-address width; words per image are capped at 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx  input  1  UART serial input, idle high, asynchronous to clk
- imem_din  output  32  write data to imem
- imem_addr  output  32  byte address to imem (word_index*4)
- imem_web  output  1  active-low write enable; 1 = no write, Fetch uses PC path
- cpu_rst  output  1  core reset; high while loading or before first load completes
- load_done  output  1  high once the last word of an image is written
- frame_err  output  1  sticky; stop bit sampled 0 on any byte; cleared by rst

Behaviour:
- Reset values: imem_din=0, imem_addr=0, imem_web=1, cpu_rst=1, load_done=0, frame_err=0; RX and loader FSMs go to IDLE/WAIT_CNT.
- rx passes through a 2-flop synchronizer (reset value 1) before use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge moves to START.
  - START: samples at CLKS_PER_BIT/2. If the line is still 0, go to DATA; else it was a glitch, return to IDLE.
  - DATA: samples 8 bits, LSB first, each CLKS_PER_BIT apart.
  - STOP: samples one CLKS_PER_BIT later. A 1 gives a one-cycle byte_valid with the byte. A 0 sets frame_err, the byte is dropped, and the FSM returns to IDLE.
- Loader FSM states: WAIT_CNT, RECV, WRITE, DONE.
  - WAIT_CNT: the first valid byte is the word count N. Clamp N to 2^ADDR_WIDTH if larger, and set word_index=0.
    - N=0: go to DONE immediately; load_done=1, cpu_rst=0, no writes.
    - N>0: go to RECV.
  - RECV: byte k (0..3) goes into bits [8k+7:8k]. After the 4th byte go to WRITE.
  - WRITE: exactly one cycle. imem_web=0, imem_din=assembled word, imem_addr=word_index<<2.
    - The next cycle imem_web returns to 1; imem_addr and imem_din hold their values until the next WRITE.
    - word_index increments. If word_index reaches N go to DONE, else go to RECV with byte counter 0.
  - DONE: load_done=1 and cpu_rst=0, registered and asserted the cycle after the last WRITE.
- Reload: a valid byte arriving in DONE is a new count byte.
  - Re-asserts cpu_rst=1 and clears load_done in the next cycle.
  - Processed exactly as in WAIT_CNT; memory is overwritten from address 0.
- Bytes beyond N in an image are treated as the next count byte (DONE reload path).
- cpu_rst stays 1 throughout WAIT_CNT/RECV/WRITE, so the core never fetches during a write.
- A framing error mid-word does not advance the byte counter; the loader simply waits for the next good byte.
- rst asserted mid-byte or mid-image: all state is discarded, the partial word is never written, and the outputs return to their reset values.
- imem_web=0 occurs only in WRITE; never two consecutive low cycles.

Test Plan:
- Reset/idle: CLKS_PER_BIT=4, rst 2 cycles, rx=1 → imem_web=1, cpu_rst=1, load_done=0, frame_err=0; nothing changes for 200 cycles.
- Single word: send 0x01, 0x13, 0x05, 0x50, 0x00 → one cycle of imem_web=0 with imem_addr=0x0, imem_din=0x00500513; load_done=1 and cpu_rst=0 the following cycle.
- Three words: N=3, words 0x11111111, 0x22222222, 0x33333333 → exactly 3 write strobes at addresses 0x0, 0x4, 0x8 with the matching data; no other imem_web=0 cycles.
- Zero count and clamp: N=0x00 → load_done=1 with no writes. Then, with ADDR_WIDTH=2, N=0x09 → only 4 writes, addresses 0x0–0xC, then DONE.
- Framing error: within the second byte of a word, drive a stop bit of 0, then resend a valid byte → frame_err=1 and stays 1; the word assembles from the good bytes only; the write address is unchanged.
- Reload and mid-load reset: after DONE send N=1 → cpu_rst=1 the cycle after the byte, then 0 after the new write at 0x0. A separate run asserts rst after 2 of 4 data bytes → no write occurs, and a subsequent full image loads from address 0.
